pc_fetch_ctrl: RTL and testbench

- Owns the architectural PC register and sequences instruction fetch around the combinational next-PC unit.
- Issues a request/ack fetch to instruction memory and holds the fetched instruction until the core retires it.
- On retire, commits the next-PC value supplied by the next-PC unit. Misaligned redirect targets and fetch timeouts are trapped to a fixed vector.
- Sits between the next-PC unit, instruction memory and the core datapath; also provides halt/resume for debug.

---
 rtl/pc_fetch_ctrl.sv | 110 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: architectural PC owner sequencing request/ack instruction fetch, retire, traps and debug halt
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc_in,
  input  logic [2:0]  npc_op,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        exec_done,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        retire,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] trap_epc,
  output logic [31:0] retire_cnt
);
  localparam logic [2:0] NPC_PLUS4 = 3'b000;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, trap_epc_q, trap_epc_d, retire_cnt_q, retire_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] trap_cause_q, trap_cause_d;
  logic retire_q, retire_d, trap_q, trap_d;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    trap_epc_d = trap_epc_q;
    trap_cause_d = trap_cause_q;
    retire_cnt_d = retire_cnt_q;
    cnt_d = '0;
    retire_d = 1'b0;
    trap_d = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = EXEC;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          trap_d = 1'b1;
          trap_cause_d = 2'b10;
          trap_epc_d = pc_q;
          pc_d = TRAP_PC;
        end else cnt_d = cnt_q + 1'b1;
      end
      EXEC: begin
        if (exec_done && !stall) begin
          retire_d = 1'b1;
          retire_cnt_d = retire_cnt_q + 32'd1;
          state_d = halt_req ? HALT : FETCH;
          if (npc_op != NPC_PLUS4 && npc_in[1:0] != 2'b00) begin
            trap_d = 1'b1;
            trap_cause_d = 2'b01;
            trap_epc_d = pc_q;
            pc_d = TRAP_PC;
          end else pc_d = npc_in;
        end
      end
      HALT: state_d = resume ? FETCH : HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BOOT;
      pc_q <= RESET_PC;
      instr_q <= '0;
      trap_epc_q <= '0;
      trap_cause_q <= '0;
      retire_cnt_q <= '0;
      cnt_q <= '0;
      retire_q <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      trap_epc_q <= trap_epc_d;
      trap_cause_q <= trap_cause_d;
      retire_cnt_q <= retire_cnt_d;
      cnt_q <= cnt_d;
      retire_q <= retire_d;
      trap_q <= trap_d;
    end
  end
  assign pc = pc_q;
  assign imem_addr = pc_q;
  assign imem_req = state_q == FETCH;
  assign instr_valid = state_q == EXEC;
  assign halted = state_q == HALT;
  assign instr = instr_q;
  assign retire = retire_q;
  assign trap = trap_q;
  assign trap_cause = trap_cause_q;
  assign trap_epc = trap_epc_q;
  assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed plus randomized transaction checks of pc_fetch_ctrl against a transaction-level model
module tb_pc_fetch_ctrl;
  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam int TO = 16;
  localparam logic [2:0] PLUS4 = 3'b000, BRANCH = 3'b001, JUMP = 3'b010, JALR = 3'b100;
  logic clk = 1'b0, rstn = 1'b0;
  logic [31:0] npc_in = '0, imem_rdata = '0;
  logic [2:0] npc_op = PLUS4;
  logic imem_ack = 1'b0, exec_done = 1'b0, stall = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] pc, imem_addr, instr, trap_epc, retire_cnt;
  logic imem_req, instr_valid, retire, halted, trap;
  logic [1:0] trap_cause;
  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] m_pc = '0, m_epc = '0, m_rc = '0;
  logic [1:0] m_cause = '0;
  pc_fetch_ctrl #(.RESET_PC(32'h0), .TRAP_PC(TRAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .npc_in(npc_in), .npc_op(npc_op), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .exec_done(exec_done), .stall(stall), .halt_req(halt_req),
    .resume(resume), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
    .instr_valid(instr_valid), .retire(retire), .halted(halted), .trap(trap),
    .trap_cause(trap_cause), .trap_epc(trap_epc), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input int d, input logic [31:0] word);
    chk("fetch_req", imem_req, 1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_ivalid", instr_valid, 0);
    for (int i = 0; i < d; i++) begin
      imem_ack = 1'b0;
      resume = 1'($urandom_range(0, 1));
      step;
      resume = 1'b0;
      if ((i + 1) % TO == 0) begin
        m_epc = m_pc;
        m_pc = TRAP;
        m_cause = 2'b10;
      end
      chk("to_trap", trap, ((i + 1) % TO == 0) ? 1 : 0);
      chk("to_cause", trap_cause, m_cause);
      chk("to_epc", trap_epc, m_epc);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_req", imem_req, 1);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    step;
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("ack_ivalid", instr_valid, 1);
    chk("ack_instr", instr, word);
    chk("ack_trap", trap, 0);
    chk("ack_req", imem_req, 0);
    chk("retire_once", retire, 0);
  endtask
  task automatic exec(input logic [2:0] op, input logic [31:0] npc, input logic h, input int s);
    logic mis;
    npc_op = op;
    npc_in = npc;
    for (int i = 0; i < s; i++) begin
      stall = 1'b1;
      exec_done = 1'($urandom_range(0, 1));
      step;
      chk("stall_retire", retire, 0);
      chk("stall_pc", pc, m_pc);
      chk("stall_ivalid", instr_valid, 1);
    end
    stall = 1'b0;
    exec_done = 1'b1;
    halt_req = h;
    step;
    exec_done = 1'b0;
    halt_req = 1'b0;
    mis = op != PLUS4 && npc[1:0] != 2'b00;
    m_rc = m_rc + 1;
    if (mis) begin
      m_epc = m_pc;
      m_pc = TRAP;
      m_cause = 2'b01;
    end else m_pc = npc;
    chk("ret_pulse", retire, 1);
    chk("ret_trap", trap, mis);
    chk("ret_cnt", retire_cnt, m_rc);
    chk("ret_pc", pc, m_pc);
    chk("ret_cause", trap_cause, m_cause);
    chk("ret_epc", trap_epc, m_epc);
    chk("ret_halted", halted, h);
    chk("ret_req", imem_req, !h);
  endtask
  task automatic halt_resume(input int k, input logic both);
    for (int i = 0; i < k; i++) begin
      halt_req = 1'($urandom_range(0, 1));
      step;
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, m_pc);
      chk("halt_req", imem_req, 0);
      chk("halt_ivalid", instr_valid, 0);
      chk("halt_retire", retire, 0);
    end
    resume = 1'b1;
    halt_req = both;
    step;
    resume = 1'b0;
    halt_req = 1'b0;
    chk("resume_halted", halted, 0);
    chk("resume_req", imem_req, 1);
    chk("resume_addr", imem_addr, m_pc);
  endtask
  initial begin
    int c0;
    logic [31:0] r;
    logic [2:0] ops [4];
    ops = '{PLUS4, BRANCH, JUMP, JALR};
    step;
    step;
    chk("rst_pc", pc, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instr, 0);
    chk("rst_cnt", retire_cnt, 0);
    chk("rst_cause", trap_cause, 0);
    chk("rst_epc", trap_epc, 0);
    chk("rst_bits", {instr_valid, retire, halted, trap}, 0);
    rstn = 1'b1;
    chk("boot_req", imem_req, 0);
    step;
    c0 = cyc;
    fetch(0, 32'h13);
    exec(PLUS4, 32'h4, 0, 0);
    chk("cpi", cyc - c0, 2);
    fetch(0, 32'h13);
    exec(PLUS4, 32'h8, 0, 0);
    fetch(0, 32'h13);
    exec(PLUS4, 32'hC, 0, 0);
    fetch(0, 32'h13);
    exec(PLUS4, 32'h10, 0, 0);
    chk("seq_cnt", retire_cnt, 4);
    fetch(0, 32'h000080E7);
    exec(JALR, 32'h23, 0, 0);
    chk("jalr_epc", trap_epc, 32'h10);
    chk("jalr_cause", trap_cause, 2'b01);
    chk("jalr_addr", imem_addr, 32'h100);
    fetch(0, 32'h6F);
    exec(JUMP, 32'h8, 0, 0);
    fetch(0, 32'h63);
    exec(BRANCH, 32'h40, 0, 0);
    chk("br_addr", imem_addr, 32'h40);
    fetch(0, 32'h6F);
    exec(JUMP, 32'h20, 0, 0);
    fetch(TO, 32'h13);
    chk("to_epc20", trap_epc, 32'h20);
    chk("to_cause10", trap_cause, 2'b10);
    exec(JUMP, 32'h20, 0, 0);
    fetch(TO - 1, 32'h13);
    chk("late_ack_cause", trap_cause, 2'b10);
    exec(PLUS4, 32'h24, 1, 5);
    halt_resume(3, 1);
    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      fetch(($urandom_range(0, 7) == 0) ? $urandom_range(14, 34) : $urandom_range(0, 4), $urandom);
      exec(ops[$urandom_range(0, 3)], ($urandom_range(0, 1) == 1) ? {r[31:2], 2'b00} : r,
           ($urandom_range(0, 5) == 0), $urandom_range(0, 3));
      if (halted) halt_resume($urandom_range(0, 4), 1'($urandom_range(0, 1)));
    end
    fetch(0, 32'h6F);
    exec(JUMP, 32'h80, 0, 0);
    chk("pre_rst_addr", imem_addr, 32'h80);
    step;
    step;
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_pc", pc, 0);
    chk("arst_cnt", retire_cnt, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_epc", trap_epc, 0);
    imem_ack = 1'b1;
    step;
    imem_ack = 1'b0;
    chk("arst_hold_req", imem_req, 0);
    rstn = 1'b1;
    m_pc = '0;
    m_rc = '0;
    m_epc = '0;
    m_cause = '0;
    imem_ack = 1'b1;
    chk("boot2_req", imem_req, 0);
    step;
    imem_ack = 1'b0;
    chk("boot2_ivalid", instr_valid, 0);
    fetch(0, 32'h13);
    exec(PLUS4, 32'h4, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
